// File: rtl/ttt_game_controller.sv
// ttt_game_controller: tic-tac-toe referee and AI-handshake initiator.
//   Holds the 3x3 board, validates human moves, issues a one-cycle ai_start, waits for
//   a rising edge on ai_done and applies the AI cell. A missing or illegal AI cell is
//   replaced by a fallback move. Checks for a win or draw after every move.
// Ports:
//   clk, rst (async, active-low)
//   new_game          - pulse, restarts the game from any state
//   player_move_valid - human move strobe, player_move = cell 0-8
//   ai_tick, ai_done  - AI chosen cell and completion flag (rising edge used)
//   cell_position     - board, cell k at [2k+1:2k]; 00 empty, 01 human, 10 AI
//   ai_start          - one-cycle AI request
//   human_turn, game_over, winner (00 none, 01 human, 10 AI, 11 draw), move_count
//   illegal_move, ai_fault - one-cycle pulses
// Build option: define TTT_AI_FIRST_EN to let the AI open every game.
module ttt_game_controller #(
    parameter int unsigned AI_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        player_move_valid,
    input  logic [3:0]  player_move,
    input  logic [3:0]  ai_tick,
    input  logic        ai_done,
    output logic [17:0] cell_position,
    output logic        ai_start,
    output logic        human_turn,
    output logic        illegal_move,
    output logic        ai_fault,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  move_count
);

    localparam int unsigned TimerW = $clog2(AI_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle, StWaitHuman, StCheckHuman, StStartAi,
        StWaitAi, StApplyAi, StCheckAi, StGameOver
    } state_e;

`ifdef TTT_AI_FIRST_EN
    localparam state_e NewGameSt = StStartAi;
`else
    localparam state_e NewGameSt = StWaitHuman;
`endif

    state_e             state_q, state_d;
    logic [17:0]        board_q, board_d;
    logic [3:0]         count_q, count_d;
    logic [1:0]         winner_q, winner_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [3:0]         ai_move_q, ai_move_d;
    logic               timeout_q, timeout_d;
    logic               illegal_q, illegal_d;
    logic               fault_q, fault_d;
    logic               ai_done_q;
    logic               done_rise;
    logic [3:0]         fb_idx;

    // Out-of-range indices read as occupied so they are never legal.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        cell_at = 2'b11;
        for (int k = 0; k < 9; k++) begin
            if (idx == 4'(k)) cell_at = b[2*k +: 2];
        end
    endfunction

    function automatic logic [17:0] put_cell(input logic [17:0] b, input logic [3:0] idx,
                                             input logic [1:0] val);
        put_cell = b;
        for (int k = 0; k < 9; k++) begin
            if (idx == 4'(k)) put_cell[2*k +: 2] = val;
        end
    endfunction

    function automatic logic has_line(input logic [17:0] b, input logic [1:0] p);
        logic [1:0] c [9];
        for (int k = 0; k < 9; k++) c[k] = b[2*k +: 2];
        has_line = (c[0] == p && c[1] == p && c[2] == p) ||
                   (c[3] == p && c[4] == p && c[5] == p) ||
                   (c[6] == p && c[7] == p && c[8] == p) ||
                   (c[0] == p && c[3] == p && c[6] == p) ||
                   (c[1] == p && c[4] == p && c[7] == p) ||
                   (c[2] == p && c[5] == p && c[8] == p) ||
                   (c[0] == p && c[4] == p && c[8] == p) ||
                   (c[2] == p && c[4] == p && c[6] == p);
    endfunction

    assign done_rise = ai_done & ~ai_done_q;

    // Fallback cell: centre if free, else the lowest-index empty cell.
    always_comb begin
        fb_idx = 4'd4;
        if (board_q[9:8] != 2'b00) begin
            fb_idx = 4'd0;
            for (int k = 8; k >= 0; k--) begin
                if (board_q[2*k +: 2] == 2'b00) fb_idx = 4'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        count_d   = count_q;
        winner_d  = winner_q;
        timer_d   = timer_q;
        ai_move_d = ai_move_q;
        timeout_d = timeout_q;
        illegal_d = 1'b0;
        fault_d   = 1'b0;
        if (new_game) begin
            board_d   = '0;
            count_d   = '0;
            winner_d  = 2'b00;
            timer_d   = '0;
            timeout_d = 1'b0;
            state_d   = NewGameSt;
        end else begin
            unique case (state_q)
                StWaitHuman: begin
                    if (player_move_valid) begin
                        if (cell_at(board_q, player_move) == 2'b00) begin
                            board_d = put_cell(board_q, player_move, 2'b01);
                            count_d = count_q + 4'd1;
                            state_d = StCheckHuman;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                StCheckHuman: begin
                    if (has_line(board_q, 2'b01)) begin
                        winner_d = 2'b01;
                        state_d  = StGameOver;
                    end else if (count_q == 4'd9) begin
                        winner_d = 2'b11;
                        state_d  = StGameOver;
                    end else begin
                        state_d = StStartAi;
                    end
                end
                StStartAi: begin
                    timer_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = StWaitAi;
                end
                StWaitAi: begin
                    if (done_rise) begin
                        ai_move_d = ai_tick;
                        state_d   = StApplyAi;
                    end else if (timer_q == TimerW'(AI_TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = StApplyAi;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StApplyAi: begin
                    if (!timeout_q && cell_at(board_q, ai_move_q) == 2'b00) begin
                        board_d = put_cell(board_q, ai_move_q, 2'b10);
                    end else begin
                        board_d = put_cell(board_q, fb_idx, 2'b10);
                        fault_d = 1'b1;
                    end
                    count_d = count_q + 4'd1;
                    state_d = StCheckAi;
                end
                StCheckAi: begin
                    if (has_line(board_q, 2'b10)) begin
                        winner_d = 2'b10;
                        state_d  = StGameOver;
                    end else if (count_q == 4'd9) begin
                        winner_d = 2'b11;
                        state_d  = StGameOver;
                    end else begin
                        state_d = StWaitHuman;
                    end
                end
                StIdle, StGameOver: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            board_q   <= '0;
            count_q   <= '0;
            winner_q  <= 2'b00;
            timer_q   <= '0;
            ai_move_q <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            ai_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            count_q   <= count_d;
            winner_q  <= winner_d;
            timer_q   <= timer_d;
            ai_move_q <= ai_move_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
            ai_done_q <= ai_done;
        end
    end

    assign cell_position = board_q;
    assign ai_start      = (state_q == StStartAi);
    assign human_turn    = (state_q == StWaitHuman);
    assign game_over     = (state_q == StGameOver);
    assign illegal_move  = illegal_q;
    assign ai_fault      = fault_q;
    assign winner        = winner_q;
    assign move_count    = count_q;

endmodule

// File: tb/tb_ttt_game_controller.sv
module tb_ttt_game_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        new_game = 1'b0;
    logic        player_move_valid = 1'b0;
    logic [3:0]  player_move = '0;
    logic [3:0]  ai_tick = '0;
    logic        ai_done = 1'b0;
    logic [17:0] cell_position;
    logic        ai_start, human_turn, illegal_move, ai_fault, game_over;
    logic [1:0]  winner;
    logic [3:0]  move_count;

    ttt_game_controller #(.AI_TIMEOUT(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .new_game          (new_game),
        .player_move_valid (player_move_valid),
        .player_move       (player_move),
        .ai_tick           (ai_tick),
        .ai_done           (ai_done),
        .cell_position     (cell_position),
        .ai_start          (ai_start),
        .human_turn        (human_turn),
        .illegal_move      (illegal_move),
        .ai_fault          (ai_fault),
        .game_over         (game_over),
        .winner            (winner),
        .move_count        (move_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ng, pmv;
        logic [3:0]  pm, tick;
        logic        done;
        logic [17:0] cells;
        logic        st, ht, il, fl, go;
        logic [1:0]  win;
        logic [3:0]  mc;
    } vec_t;

    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;
    logic [28:0]   exp_q [$];
    vec_t          tbl [$];
    logic [17:0]   exp_board;
    int            exp_mc;

    function automatic vec_t mk(input int ng, input int pmv, input int pm, input int tick,
                                input int done, input int cells, input int st, input int ht,
                                input int il, input int fl, input int go, input int win,
                                input int mc);
        vec_t v;
        v.ng = ng[0];  v.pmv = pmv[0]; v.pm = 4'(pm); v.tick = 4'(tick); v.done = done[0];
        v.cells = 18'(cells); v.st = st[0]; v.ht = ht[0]; v.il = il[0]; v.fl = fl[0];
        v.go = go[0]; v.win = 2'(win); v.mc = 4'(mc);
        return v;
    endfunction

    function automatic logic [28:0] dut_out();
        return {cell_position, ai_start, human_turn, illegal_move, ai_fault, game_over,
                winner, move_count};
    endfunction

    task automatic check(input string name, input logic [28:0] got, input logic [28:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got cells=%h st/ht/il/fl/go=%b win=%b mc=%0d, expected cells=%h st/ht/il/fl/go=%b win=%b mc=%0d",
                     name, got[28:11], got[10:6], got[5:4], got[3:0],
                     exp[28:11], exp[10:6], exp[5:4], exp[3:0]);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, compare after the edge.
    task automatic step(input vec_t v, input string name);
        new_game = v.ng; player_move_valid = v.pmv; player_move = v.pm;
        ai_tick = v.tick; ai_done = v.done;
        exp_q.push_back({v.cells, v.st, v.ht, v.il, v.fl, v.go, v.win, v.mc});
        @(posedge clk);
        #1;
        check(name, dut_out(), exp_q.pop_front());
    endtask

    // One human move followed by a normal AI answer, tracked with the bench board model.
    task automatic play_round(input int h, input int a, input string name);
        exp_board[2*h +: 2] = 2'b01; exp_mc++;
        step(mk(0, 1, h, 0, 0, exp_board, 0, 0, 0, 0, 0, 0, exp_mc), {name, "_human"});
        step(mk(0, 0, 0, 0, 0, exp_board, 1, 0, 0, 0, 0, 0, exp_mc), {name, "_start"});
        step(mk(0, 0, 0, 0, 0, exp_board, 0, 0, 0, 0, 0, 0, exp_mc), {name, "_wait"});
        step(mk(0, 0, 0, a, 1, exp_board, 0, 0, 0, 0, 0, 0, exp_mc), {name, "_done"});
        exp_board[2*a +: 2] = 2'b10; exp_mc++;
        step(mk(0, 0, 0, a, 0, exp_board, 0, 0, 0, 0, 0, 0, exp_mc), {name, "_apply"});
        step(mk(0, 0, 0, 0, 0, exp_board, 0, 1, 0, 0, 0, 0, exp_mc), {name, "_back"});
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_out(), 29'd0);
        rst = 1'b1;

        // Game A: happy path, illegal moves, ignored strobes, human row-0 win.
        tbl.push_back(mk(1, 0, 0, 0, 0, 'h0,     0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 'h1,     0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h1,     1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h1,     0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4, 1, 'h1,     0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4, 1, 'h201,   0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h201,   0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 'h201,   0, 1, 1, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h201,   0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 9, 0, 0, 'h201,   0, 1, 1, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h201,   0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 1, 0, 0, 'h205,   0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h205,   1, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 1, 3, 0, 0, 'h205,   0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 5, 1, 'h205,   0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 5, 0, 'hA05,   0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'hA05,   0, 1, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 1, 2, 0, 0, 'hA15,   0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'hA15,   0, 0, 0, 0, 1, 1, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'hA15,   0, 0, 0, 0, 1, 1, 5));
        tbl.push_back(mk(0, 1, 3, 0, 0, 'hA15,   0, 0, 0, 0, 1, 1, 5));
        // Game B: AI picks occupied cell (centre fallback), then out-of-range cell.
        tbl.push_back(mk(1, 0, 0, 0, 0, 'h0,     0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 'h1,     0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h1,     1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h1,     0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h1,     0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h201,   0, 0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h201,   0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 1, 0, 0, 'h205,   0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h205,   1, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h205,   0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 15, 1, 'h205,  0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 15, 0, 'h225,  0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h225,   0, 1, 0, 0, 0, 0, 4));
        foreach (tbl[i]) step(tbl[i], $sformatf("table_%0d", i));

        // Draw: human 0,2,3,7,8 against AI 4,1,5,6.
        exp_board = '0; exp_mc = 0;
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "draw_new");
        play_round(0, 4, "draw_r1");
        play_round(2, 1, "draw_r2");
        play_round(3, 5, "draw_r3");
        play_round(7, 6, "draw_r4");
        step(mk(0, 1, 8, 0, 0, 'h16A59, 0, 0, 0, 0, 0, 0, 9), "draw_ninth");
        step(mk(0, 0, 0, 0, 0, 'h16A59, 0, 0, 0, 0, 1, 3, 9), "draw_over");

        // Timeout with ai_done stuck high: centre taken, so cell 0 is the fallback.
        step(mk(1, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0), "to_new");
        step(mk(0, 1, 4, 0, 0, 'h100, 0, 0, 0, 0, 0, 0, 1), "to_human");
        step(mk(0, 0, 0, 0, 0, 'h100, 1, 0, 0, 0, 0, 0, 1), "to_start");
        step(mk(0, 0, 0, 2, 1, 'h100, 0, 0, 0, 0, 0, 0, 1), "to_enter_wait");
        for (int i = 0; i < 64; i++)
            step(mk(0, 0, 0, 2, 1, 'h100, 0, 0, 0, 0, 0, 0, 1), $sformatf("to_wait_%0d", i));
        step(mk(0, 0, 0, 2, 1, 'h102, 0, 0, 0, 1, 0, 0, 2), "to_fallback");
        step(mk(0, 0, 0, 0, 0, 'h102, 0, 1, 0, 0, 0, 0, 2), "to_back");

        // new_game while waiting on the AI; the late done must be ignored.
        step(mk(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0), "ng_new");
        step(mk(0, 1, 0, 0, 0, 'h1, 0, 0, 0, 0, 0, 0, 1), "ng_human");
        step(mk(0, 0, 0, 0, 0, 'h1, 1, 0, 0, 0, 0, 0, 1), "ng_start");
        step(mk(0, 0, 0, 0, 0, 'h1, 0, 0, 0, 0, 0, 0, 1), "ng_wait0");
        step(mk(0, 0, 0, 0, 0, 'h1, 0, 0, 0, 0, 0, 0, 1), "ng_wait1");
        step(mk(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0), "ng_mid_wait");
        step(mk(0, 0, 0, 4, 1, 0,   0, 1, 0, 0, 0, 0, 0), "ng_late_done");
        step(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0), "ng_done_low");
        step(mk(0, 1, 0, 0, 0, 'h1, 0, 0, 0, 0, 0, 0, 1), "ng_human2");
        step(mk(0, 0, 0, 0, 0, 'h1, 1, 0, 0, 0, 0, 0, 1), "ng_start2");
        step(mk(0, 0, 0, 0, 0, 'h1, 0, 0, 0, 0, 0, 0, 1), "ng_wait2");
        step(mk(0, 0, 0, 8, 1, 'h1, 0, 0, 0, 0, 0, 0, 1), "ng_done2");
        step(mk(0, 0, 0, 8, 0, 'h20001, 0, 0, 0, 0, 0, 0, 2), "ng_apply2");
        step(mk(0, 0, 0, 0, 0, 'h20001, 0, 1, 0, 0, 0, 0, 2), "ng_back2");

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b0;
        #1;
        check("async_reset", dut_out(), 29'd0);
        @(posedge clk);
        #1;
        check("reset_hold", dut_out(), 29'd0);
        rst = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "idle_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ttt_game_controller.md
Name: ttt_game_controller

Overview:
Game referee and initiator side of the AI move handshake. Holds the authoritative 3x3 board and accepts human moves. Issues a one-cycle start to the AI agent, waits for its done, then applies the returned move, with a fallback if the move is missing or illegal. After every move it checks win and draw, and reports game status to the UI/display layer.

Parameters:
AI_TIMEOUT, 64, cycles to wait in WAIT_AI for an ai_done rising edge before a fallback move is forced (minimum 2).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
new_game  input  1  one-cycle pulse: clear board and start a game; honoured in every state
player_move_valid  input  1  human move strobe
player_move  input  4  human cell index, 0-8
ai_tick  input  4  AI chosen cell, 0-8
ai_done  input  1  AI completion; only its rising edge is used
cell_position  output  18  board; cell k = bits [2k+1:2k]; 00 empty, 01 human, 10 AI
ai_start  output  1  one-cycle request to the AI agent
human_turn  output  1  high while in WAIT_HUMAN
illegal_move  output  1  one-cycle pulse: human move rejected
ai_fault  output  1  one-cycle pulse: AI timed out or returned an illegal cell
game_over  output  1  high in GAME_OVER
winner  output  2  00 none, 01 human, 10 AI, 11 draw
move_count  output  4  cells occupied, 0-9

Behaviour:
- Reset (async, rst=0):
  - cell_position=0, state=IDLE, ai_start=0, illegal_move=0, ai_fault=0, winner=00, move_count=0, timer=0, ai_done_q=0.
- Edge detection: ai_done is registered every cycle into ai_done_q. done_rise = ai_done & !ai_done_q.
- IDLE:
  - All outputs at reset values.
  - new_game → WAIT_HUMAN.
- WAIT_HUMAN (human_turn=1):
  - On player_move_valid: legal = player_move ≤ 8 and the cell is 00.
  - Legal: cell ← 01, move_count+1, → CHECK_HUMAN. The board updates on the accepting edge.
  - Illegal: illegal_move=1 for exactly one cycle, board unchanged, remain in WAIT_HUMAN.
  - player_move_valid is ignored in all other states, with no illegal_move pulse.
- CHECK_HUMAN:
  - A completed line of 01 (8 lines: 3 rows, 3 columns, 2 diagonals) → winner=01, GAME_OVER.
  - Else move_count==9 → winner=11, GAME_OVER.
  - Else → START_AI.
- START_AI:
  - ai_start=1 for this cycle only; timer←0 → WAIT_AI.
  - cell_position is stable from START_AI until APPLY_AI.
- WAIT_AI:
  - done_rise → latch ai_tick into ai_move, → APPLY_AI.
  - Else timer==AI_TIMEOUT-1 → set timeout flag, → APPLY_AI.
  - Else timer+1.
  - done_rise is checked before timeout when both occur in the same cycle.
  - done_rise in any other state is ignored.
- APPLY_AI:
  - If there was no timeout and ai_move ≤ 8 and that cell is 00: cell ← 10.
  - Otherwise: fallback. Centre (cell 4) if empty, else the lowest-index empty cell; cell ← 10, ai_fault=1 for one cycle.
  - move_count+1 → CHECK_AI.
  - An empty cell always exists here, because CHECK_HUMAN already routed a full board to draw.
- CHECK_AI:
  - Line of 10 → winner=10, GAME_OVER.
  - Else move_count==9 → winner=11, GAME_OVER.
  - Else → WAIT_HUMAN.
- GAME_OVER: game_over=1; board and winner hold until new_game.
- new_game in any state (highest priority, including mid WAIT_AI):
  - Board←0, move_count←0, winner←00, timer←0, pulses cleared, → WAIT_HUMAN.
  - A pending AI response is discarded; only a fresh done_rise after the next ai_start counts.
- AI agent requirement: ai_done must return low between requests. If it stays high, no rising edge occurs and the timeout fallback applies.
- Latency:
  - Legal human move to ai_start: 2 cycles.
  - ai_done rise to board update: 2 cycles (WAIT_AI edge, then APPLY_AI edge).

Optional Feature:
TTT_AI_FIRST_EN:
- Defined: new_game → START_AI, so the AI opens every game.
- Undefined: new_game → WAIT_HUMAN, so the human opens.
- All other behaviour is identical.

Test Plan:
- Happy path: new_game, human cell 0; AI raises done with ai_tick=4 → cell_position=18'h00201 after APPLY_AI, move_count=2, human_turn=1.
- Human win: human 0,1,2 while AI answers 4,5 → winner=01 and game_over=1 in the cycle after cell 2 is written; no third ai_start.
- Illegal moves: human plays cell 0 twice, then cell 9 → illegal_move pulses twice, board unchanged, still WAIT_HUMAN.
- AI fault:
  - Occupied cell: AI returns ai_tick=0 while cell 0 is human → ai_fault pulse, AI takes cell 4.
  - Timeout: no done for AI_TIMEOUT=64 cycles → ai_fault, lowest-index empty cell written as 10.
- Draw: sequence human 0,2,3,7,8 / AI 4,1,5,6 → after the ninth move winner=11, move_count=9.
- new_game mid WAIT_AI, then a late done_rise → board cleared, WAIT_HUMAN, late done ignored; rst low mid-game → all outputs at reset values immediately.
